mux_scan_controller: RTL and testbench
======================================

// Module: mux_scan_controller
// PURPOSE
//  Upstream/downstream controller for the 4:1 gate-level multiplexer. On start, walks the
//  mux select lines over the enabled channels, waits for gate-delay settling, samples the
//  mux output, and returns one 4-bit snapshot via a valid/ready handshake.
//  Sits between the control logic and the mux: drives address0/address1, consumes mux_out.
// PARAMETERS
//  SETTLE_CYCLES  2  cycles the address is held before sampling; legal range 1..15.
//                    The mux path is 3 gate levels at 50 units each, 150 total.
//                    At SETTLE_CYCLES=1 the clock period must exceed 150 time units.
// PORTS
//  clk           in   1  single clock, rising edge
//  reset_n       in   1  asynchronous, active-low reset
//  start         in   1  request a scan; accepted only in IDLE
//  chan_mask     in   4  bit i=1 -> scan channel i; captured when start is accepted
//  address0      out  1  mux select LSB
//  address1      out  1  mux select MSB
//  mux_out       in   1  mux output
//  sample        out  4  bit i = captured value of channel i; masked channels read 0
//  sample_valid  out  1  snapshot available; held until accepted
//  sample_ready  in   1  consumer accepts the snapshot when valid&ready at a rising edge
//  busy          out  1  high in every state except IDLE
//  overrun       out  1  one-cycle pulse when start=1 while not in IDLE; start is dropped
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, all outputs 0.
//    address0/1=0, sample=0, sample_valid=0, busy=0, overrun=0.
//  States: IDLE, SETUP, CAPTURE, DONE.
//  IDLE:
//    - start=1: latch chan_mask; clear sample.
//    - Go to SETUP at the lowest enabled channel, with settle count = SETTLE_CYCLES.
//    - If chan_mask=0, go straight to DONE.
//  SETUP: address holds the current channel; stays for exactly SETTLE_CYCLES cycles, then CAPTURE.
//  CAPTURE (one cycle): sample[ch] <= mux_out; address stays unchanged.
//    - Next higher enabled channel exists: go to SETUP for it.
//    - Otherwise: go to DONE.
//  DONE: sample_valid=1 and sample stable. On valid&ready: go to IDLE; sample_valid=0 next cycle.
//  Latency: N = number of enabled channels; start accepted in cycle 0.
//    - sample_valid rises in cycle N*(SETTLE_CYCLES+1)+1.
//    - mask=0 gives cycle 1.
//  Address: IDLE and DONE hold the last driven channel. Changes happen only on the
//    CAPTURE->SETUP edge or the IDLE->SETUP edge, never mid-settle.
//  chan_mask changes after acceptance are ignored. sample_ready is ignored outside DONE.
//  start is ignored in SETUP, CAPTURE and DONE, and overrun pulses for 1 cycle.
//    - Also applies to start in the same cycle as the DONE handshake (state not yet IDLE).
//  Channels are scanned in ascending index order only; no wrap-around within a scan.
//  reset_n low mid-scan: scan is aborted, nothing partial is presented, outputs return to reset values.
// STRUCTURE
//  Shared include mux_scan_defs.vh holds:
//    - state encodings (2 bits: IDLE=0, SETUP=1, CAPTURE=2, DONE=3)
//    - NUM_CH=4 and the default SETTLE_CYCLES.
//  Sub-module settle_timer: 4-bit down-counter with load/enable, asynchronous active-low reset.
//    It raises expired when the count reaches 0.
//  Next-channel selection (lowest enabled bit above the current one) is a small combinational block in the top.
// TESTING (bench instantiates structuralMultiplexer driven by this block)
//  1. in3..0=4'b1010, mask=4'hF, SETTLE=2, ready=1 -> sample=4'b1010.
//     sample_valid rises in cycle 13; address walks 0,1,2,3.
//  2. mask=4'b0101, in=4'b1111 -> only channels 0 and 2 driven, sample=4'b0101, valid in cycle 7.
//  3. mask=4'b0000 -> valid in cycle 1, sample=0, address unchanged.
//  4. ready held 0 for 10 cycles in DONE -> valid and sample stable.
//     A start pulse in that window gives overrun=1 for 1 cycle and no new scan.
//  5. reset_n pulsed low in SETUP of channel 2 -> all outputs 0 immediately.
//     A fresh scan after release completes correctly.
//  6. Inputs change during SETUP settling (in1 0->1 before capture) -> captured bit = value at CAPTURE edge.

Source files
------------

// File: rtl/mux_scan_controller_pkg.sv
// Shared types and helpers for the 4-channel mux scan controller.
// Provides the state encoding, channel count, default settle time and a lowest-enabled-channel finder.
package mux_scan_controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int NUM_CH                = 4;
  localparam int DEFAULT_SETTLE_CYCLES = 2;

  typedef struct packed {
    logic       found;
    logic [1:0] ch;
  } chan_pick_t;

  // Lowest enabled channel whose index is >= base; base = NUM_CH means "none left".
  function automatic chan_pick_t lowest_from(input logic [NUM_CH-1:0] mask,
                                             input logic [2:0]        base);
    chan_pick_t pick;
    pick = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(base))) begin
        pick.found = 1'b1;
        pick.ch    = 2'(i);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux_scan_controller_settle_timer.sv
// 4-bit loadable down-counter that times the address settle window.
// expired is asserted whenever the count sits at zero.
module settle_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       expired
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign expired = (count == 4'd0);

endmodule

// File: rtl/mux_scan_controller.sv
// Scans the enabled inputs of a 4:1 mux in ascending order, holding each select for a settle
// window before sampling, and returns the 4-bit snapshot over a valid/ready handshake.
module mux_scan_controller
  import mux_scan_controller_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] chan_mask,
  output logic              address0,
  output logic              address1,
  input  logic              mux_out,
  output logic [NUM_CH-1:0] sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              overrun
);

  // Timer is loaded with SETTLE_CYCLES-1 so SETUP lasts exactly SETTLE_CYCLES cycles.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t            state;
  logic [1:0]        ch;
  logic [NUM_CH-1:0] mask_q;
  chan_pick_t        first_pick;
  chan_pick_t        next_pick;
  logic              timer_load;
  logic              timer_en;
  logic              expired;

  always_comb begin
    first_pick = lowest_from(chan_mask, 3'd0);
    next_pick  = lowest_from(mask_q, {1'b0, ch} + 3'd1);
  end

  assign timer_load = ((state == IDLE) && start && first_pick.found) ||
                      ((state == CAPTURE) && next_pick.found);
  assign timer_en   = (state == SETUP);

  settle_timer u_settle_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .en       (timer_en),
    .load_val (SETTLE_LOAD),
    .expired  (expired)
  );

  assign address0 = ch[0];
  assign address1 = ch[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ch           <= 2'd0;
      mask_q       <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= start && (state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            mask_q <= chan_mask;
            sample <= '0;
            busy   <= 1'b1;
            if (first_pick.found) begin
              ch    <= first_pick.ch;
              state <= SETUP;
            end else begin
              state        <= DONE;
              sample_valid <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (expired) state <= CAPTURE;
        end
        CAPTURE: begin
          sample[ch] <= mux_out;
          if (next_pick.found) begin
            ch    <= next_pick.ch;
            state <= SETUP;
          end else begin
            state        <= DONE;
            sample_valid <= 1'b1;
          end
        end
        DONE: begin
          if (sample_ready) begin
            state        <= IDLE;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_controller.sv
// Directed bench for mux_scan_controller with a behavioural 4:1 mux on its select lines.
module tb_mux_scan_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] chan_mask;
  logic       address0;
  logic       address1;
  logic       mux_out;
  logic [3:0] sample;
  logic       sample_valid;
  logic       sample_ready;
  logic       busy;
  logic       overrun;
  logic [3:0] mux_in;

  int checks   = 0;
  int failures = 0;
  int lat;
  int addr_log [0:63];

  always #5 clk = ~clk;

  assign mux_out = mux_in[{address1, address0}];

  mux_scan_controller #(.SETTLE_CYCLES(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .chan_mask    (chan_mask),
    .address0     (address0),
    .address1     (address1),
    .mux_out      (mux_out),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .overrun      (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a scan, then scramble chan_mask; optionally change mux_in during cycle chg_cyc.
  task automatic run_scan(input logic [3:0] mask, input int chg_cyc, input logic [3:0] chg_in,
                          output int latency);
    int cyc;
    chan_mask = mask;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    chan_mask = ~mask;
    cyc = 1;
    addr_log[1] = int'({address1, address0});
    while (!sample_valid && cyc < 60) begin
      if (cyc == chg_cyc) mux_in = chg_in;
      tick();
      cyc++;
      addr_log[cyc] = int'({address1, address0});
    end
    latency = sample_valid ? cyc : -1;
  endtask

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    chan_mask    = 4'h0;
    sample_ready = 1'b1;
    mux_in       = 4'h0;
    #12;
    chk("rst_addr", {30'd0, address1, address0}, 32'd0);
    chk("rst_sample", {28'd0, sample}, 32'd0);
    chk("rst_ctrl", {29'd0, sample_valid, busy, overrun}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Test 1: full scan
    mux_in = 4'b1010;
    run_scan(4'hF, -1, 4'h0, lat);
    chk("t1_latency", lat, 32'd13);
    chk("t1_sample", {28'd0, sample}, 32'b1010);
    chk("t1_addr_c1", addr_log[1], 32'd0);
    chk("t1_addr_c3", addr_log[3], 32'd0);
    chk("t1_addr_c4", addr_log[4], 32'd1);
    chk("t1_addr_c7", addr_log[7], 32'd2);
    chk("t1_addr_c9", addr_log[9], 32'd2);
    chk("t1_addr_c10", addr_log[10], 32'd3);
    chk("t1_busy_scan", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_valid_drop", {31'd0, sample_valid}, 32'd0);
    chk("t1_busy_idle", {31'd0, busy}, 32'd0);
    chk("t1_addr_hold", {30'd0, address1, address0}, 32'd3);

    // Test 2: sparse mask
    mux_in = 4'b1111;
    run_scan(4'b0101, -1, 4'h0, lat);
    chk("t2_latency", lat, 32'd7);
    chk("t2_sample", {28'd0, sample}, 32'b0101);
    chk("t2_addr_c1", addr_log[1], 32'd0);
    chk("t2_addr_c4", addr_log[4], 32'd2);
    tick();

    // Test 3: empty mask
    run_scan(4'b0000, -1, 4'h0, lat);
    chk("t3_latency", lat, 32'd1);
    chk("t3_sample", {28'd0, sample}, 32'd0);
    chk("t3_addr_hold", {30'd0, address1, address0}, 32'd2);
    tick();

    // Test 4: back-pressure in DONE with an overrun start
    sample_ready = 1'b0;
    mux_in = 4'b0110;
    run_scan(4'hF, -1, 4'h0, lat);
    chk("t4_latency", lat, 32'd13);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) start = 1'b1;
      tick();
      if (k == 3) begin
        start = 1'b0;
        chk("t4_overrun_hi", {31'd0, overrun}, 32'd1);
      end else if (k == 4) begin
        chk("t4_overrun_lo", {31'd0, overrun}, 32'd0);
      end
      chk("t4_valid_hold", {31'd0, sample_valid}, 32'd1);
      chk("t4_sample_hold", {28'd0, sample}, 32'b0110);
    end
    sample_ready = 1'b1;
    tick();
    chk("t4_valid_drop", {31'd0, sample_valid}, 32'd0);
    tick();
    tick();
    chk("t4_no_new_scan", {31'd0, busy}, 32'd0);

    // Test 5: reset during SETUP of channel 2, then a clean scan
    mux_in    = 4'b0011;
    chan_mask = 4'hF;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("t5_addr_pre", {30'd0, address1, address0}, 32'd2);
    chk("t5_sample_pre", {28'd0, sample}, 32'b0011);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_addr", {30'd0, address1, address0}, 32'd0);
    chk("t5_rst_sample", {28'd0, sample}, 32'd0);
    chk("t5_rst_ctrl", {29'd0, sample_valid, busy, overrun}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    mux_in = 4'b0101;
    run_scan(4'hF, -1, 4'h0, lat);
    chk("t5_latency", lat, 32'd13);
    chk("t5_sample", {28'd0, sample}, 32'b0101);
    tick();

    // Test 6: input changes mid-settle
    mux_in = 4'b0000;
    run_scan(4'b0010, 2, 4'b0010, lat);
    chk("t6_latency", lat, 32'd4);
    chk("t6_addr_c1", addr_log[1], 32'd1);
    chk("t6_sample", {28'd0, sample}, 32'b0010);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
